// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and loader state encoding for the FIR coefficient path
//
// Purpose : default tap geometry, loader FSM encoding and the index-width helper
//           used by fir_coeff_loader and fir_coeff_bank.
// Contents: TAPS_WIDTH_DEFAULT, TAPS_COUNT_DEFAULT, loader_state_t,
//           idx_width(), IDX_WIDTH_DEFAULT.

package fir_pkg;

   localparam int TAPS_WIDTH_DEFAULT = 16;
   localparam int TAPS_COUNT_DEFAULT = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FULL  = 2'd2,
      ST_ERROR = 2'd3
   } loader_state_t;

   // Width of a tap index; a single-tap bank still needs a one-bit index.
   function automatic int idx_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   localparam int IDX_WIDTH_DEFAULT = idx_width(TAPS_COUNT_DEFAULT);

endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - one bank of FIR coefficient registers with a flat read bus
//
// Purpose : COUNT words of WIDTH bits, written one word per cycle, read all at once.
// Ports   : fir_clk         - clock
//           rst_active_high - asynchronous active-high reset, clears every word
//           wr_en           - write wr_data into word wr_idx on this edge
//           wr_idx          - word index 0..COUNT-1
//           wr_data         - word to store, bit-exact
//           rd_bus          - word i at bits [i*WIDTH +: WIDTH]

module fir_coeff_bank #(
   parameter int WIDTH = 16,
   parameter int COUNT = 40,
   parameter int IDX_W = 6
) (
   input  logic                     fir_clk,
   input  logic                     rst_active_high,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [COUNT*WIDTH-1:0]   rd_bus
);

   logic [WIDTH-1:0] mem [COUNT];

   // Per-word decode keeps indices beyond COUNT-1 from ever addressing storage.
   always_ff @(posedge fir_clk or posedge rst_active_high) begin
      if (rst_active_high) begin
         for (int i = 0; i < COUNT; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < COUNT; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               mem[i] <= wr_data;
            end
         end
      end
   end

   for (genvar g = 0; g < COUNT; g++) begin : g_rd
      assign rd_bus[g*WIDTH +: WIDTH] = mem[g];
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - streams FIR taps into a shadow bank and swaps it active on request
//
// Purpose : double-buffered coefficient store; the filter sees only complete banks.
// Ports   : fir_clk, rst_active_high   - clock, asynchronous active-high reset
//           s_data, s_valid, s_last    - coefficient stream, tap 0 first
//           s_ready                    - loader accepts a word this cycle
//           swap_req                   - make the complete shadow bank active
//           clear_err                  - leave ERROR
//           coeff_out                  - active bank, tap i at [i*TAPS_WIDTH +: TAPS_WIDTH]
//           swap_done                  - coeff_out has just taken the new bank
//           load_error                 - malformed load seen, waiting for clear_err
//           shadow_full                - complete shadow bank waiting for swap

module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int TAPS_WIDTH = TAPS_WIDTH_DEFAULT,
   parameter int TAPS_COUNT = TAPS_COUNT_DEFAULT
) (
   input  logic                             fir_clk,
   input  logic                             rst_active_high,
   input  logic [TAPS_WIDTH-1:0]            s_data,
   input  logic                             s_valid,
   input  logic                             s_last,
   output logic                             s_ready,
   input  logic                             swap_req,
   input  logic                             clear_err,
   output logic [TAPS_COUNT*TAPS_WIDTH-1:0] coeff_out,
   output logic                             swap_done,
   output logic                             load_error,
   output logic                             shadow_full
);

   localparam int IDX_W = idx_width(TAPS_COUNT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS_COUNT - 1);

   loader_state_t                      state;
   logic [IDX_W-1:0]                   wr_idx;
   logic                               active_ptr;   // 0: bank0 active, bank1 is shadow
   logic                               swap_pend;    // pointer moved last edge, reload coeff_out
   logic                               accept;
   logic                               wr_en0;
   logic                               wr_en1;
   logic [TAPS_COUNT*TAPS_WIDTH-1:0]   bus0;
   logic [TAPS_COUNT*TAPS_WIDTH-1:0]   bus1;
   logic [TAPS_COUNT*TAPS_WIDTH-1:0]   active_bus;

   // s_ready is registered and low only in FULL/ERROR (and reset), so it alone gates writes.
   assign accept     = s_valid && s_ready;
   assign wr_en0     = accept && active_ptr;
   assign wr_en1     = accept && !active_ptr;
   assign active_bus = active_ptr ? bus1 : bus0;

   fir_coeff_bank #(
      .WIDTH (TAPS_WIDTH),
      .COUNT (TAPS_COUNT),
      .IDX_W (IDX_W)
   ) u_bank0 (
      .fir_clk         (fir_clk),
      .rst_active_high (rst_active_high),
      .wr_en           (wr_en0),
      .wr_idx          (wr_idx),
      .wr_data         (s_data),
      .rd_bus          (bus0)
   );

   fir_coeff_bank #(
      .WIDTH (TAPS_WIDTH),
      .COUNT (TAPS_COUNT),
      .IDX_W (IDX_W)
   ) u_bank1 (
      .fir_clk         (fir_clk),
      .rst_active_high (rst_active_high),
      .wr_en           (wr_en1),
      .wr_idx          (wr_idx),
      .wr_data         (s_data),
      .rd_bus          (bus1)
   );

   always_ff @(posedge fir_clk or posedge rst_active_high) begin
      if (rst_active_high) begin
         state       <= ST_IDLE;
         wr_idx      <= '0;
         active_ptr  <= 1'b0;
         swap_pend   <= 1'b0;
         swap_done   <= 1'b0;
         coeff_out   <= '0;
         s_ready     <= 1'b0;
         load_error  <= 1'b0;
         shadow_full <= 1'b0;
      end else begin
         // Second half of a swap: the pointer already moved, now expose the new bank.
         swap_pend <= 1'b0;
         swap_done <= swap_pend;
         if (swap_pend) begin
            coeff_out <= active_bus;
         end

         case (state)
            ST_IDLE, ST_LOAD: begin
               s_ready <= 1'b1;
               if (accept) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx  <= '0;
                     s_ready <= 1'b0;
                     if (s_last) begin
                        state       <= ST_FULL;
                        shadow_full <= 1'b1;
                     end else begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                     end
                  end else if (s_last) begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                     wr_idx     <= '0;
                     s_ready    <= 1'b0;
                  end else begin
                     state  <= ST_LOAD;
                     wr_idx <= wr_idx + IDX_W'(1);
                  end
               end
            end

            ST_FULL: begin
               if (swap_req) begin
                  active_ptr  <= !active_ptr;
                  swap_pend   <= 1'b1;
                  state       <= ST_IDLE;
                  s_ready     <= 1'b1;
                  shadow_full <= 1'b0;
               end
            end

            ST_ERROR: begin
               wr_idx <= '0;
               if (clear_err) begin
                  state      <= ST_IDLE;
                  s_ready    <= 1'b1;
                  load_error <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - self-checking bench for fir_coeff_loader

module tb_fir_coeff_loader;

   localparam int TW = 16;
   localparam int TC = 40;
   localparam int BW = TW * TC;

   logic          fir_clk;
   logic          rst_active_high;
   logic [TW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic          swap_req;
   logic          clear_err;
   logic [BW-1:0] coeff_out;
   logic          swap_done;
   logic          load_error;
   logic          shadow_full;

   fir_coeff_loader #(.TAPS_WIDTH(TW), .TAPS_COUNT(TC)) dut (
      .fir_clk         (fir_clk),
      .rst_active_high (rst_active_high),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_last          (s_last),
      .s_ready         (s_ready),
      .swap_req        (swap_req),
      .clear_err       (clear_err),
      .coeff_out       (coeff_out),
      .swap_done       (swap_done),
      .load_error      (load_error),
      .shadow_full     (shadow_full)
   );

   initial fir_clk = 1'b0;
   always #5 fir_clk = ~fir_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: words of the load in progress, the bank the filter sees,
   // and the handful of conditions the rules talk about.
   logic [TW-1:0] m_buf    [TC];
   logic [TW-1:0] m_active [TC];
   logic [TW-1:0] m_coeff  [TC];
   int            m_cnt;
   bit            m_ready, m_full, m_err, m_pend, m_done;

   task automatic model_reset();
      for (int i = 0; i < TC; i++) begin
         m_buf[i] = '0; m_active[i] = '0; m_coeff[i] = '0;
      end
      m_cnt = 0; m_ready = 0; m_full = 0; m_err = 0; m_pend = 0; m_done = 0;
   endtask

   task automatic model_edge(input bit v, input logic [TW-1:0] d, input bit l,
                             input bit sw, input bit clr);
      bit acc;
      acc    = v && m_ready;
      m_done = m_pend;
      if (m_pend) begin
         for (int i = 0; i < TC; i++) m_coeff[i] = m_active[i];
      end
      m_pend = 0;
      if (m_full) begin
         if (sw) begin
            for (int i = 0; i < TC; i++) m_active[i] = m_buf[i];
            m_full = 0; m_pend = 1; m_ready = 1;
         end
      end else if (m_err) begin
         if (clr) begin
            m_err = 0; m_ready = 1;
         end
      end else if (acc) begin
         m_buf[m_cnt] = d;
         if (l && m_cnt == TC - 1) begin
            m_full = 1; m_ready = 0; m_cnt = 0;
         end else if (l || m_cnt == TC - 1) begin
            m_err = 1; m_ready = 0; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         m_ready = 1;
      end
   endtask

   function automatic logic [BW-1:0] model_flat();
      logic [BW-1:0] f;
      for (int i = 0; i < TC; i++) f[i*TW +: TW] = m_coeff[i];
      return f;
   endfunction

   task automatic check_all(input string where);
      chk({where, ".s_ready"},     BW'(s_ready),     BW'(m_ready));
      chk({where, ".load_error"},  BW'(load_error),  BW'(m_err));
      chk({where, ".shadow_full"}, BW'(shadow_full), BW'(m_full));
      chk({where, ".swap_done"},   BW'(swap_done),   BW'(m_done));
      chk({where, ".coeff_out"},   coeff_out,        model_flat());
   endtask

   task automatic drive(input bit v, input logic [TW-1:0] d, input bit l,
                        input bit sw, input bit clr, input string where);
      s_valid = v; s_data = d; s_last = l; swap_req = sw; clear_err = clr;
      @(posedge fir_clk);
      model_edge(v, d, l, sw, clr);
      #1;
      check_all(where);
      s_valid = 0; s_last = 0; swap_req = 0; clear_err = 0;
   endtask

   task automatic idle(input int n, input string where);
      for (int i = 0; i < n; i++) drive(0, $urandom, 0, 0, 0, where);
   endtask

   logic [TW-1:0] ld_data [TC];

   // Sends words 1..n from ld_data with s_last on word last_at (0 = never), random gaps.
   task automatic send_load(input int n, input int last_at, input string where);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) drive(0, $urandom, 0, 0, 0, where);
         drive(1, ld_data[i], (i + 1 == last_at), 0, 0, where);
      end
   endtask

   task automatic swap_now(input string where);
      drive(0, '0, 0, 1, 0, where);
      drive(0, '0, 0, 0, 0, where);
      chk({where, ".swap_done_pulse"}, BW'(swap_done), BW'(1));
   endtask

   task automatic async_reset(input string where);
      #2;
      rst_active_high = 1'b1;
      s_valid = 0; s_last = 0; swap_req = 0; clear_err = 0;
      #1;
      chk({where, ".rst_coeff"},   coeff_out,         '0);
      chk({where, ".rst_ready"},   BW'(s_ready),      '0);
      chk({where, ".rst_full"},    BW'(shadow_full),  '0);
      chk({where, ".rst_err"},     BW'(load_error),   '0);
      chk({where, ".rst_done"},    BW'(swap_done),    '0);
      model_reset();
      @(negedge fir_clk);
      rst_active_high = 1'b0;
   endtask

   initial begin
      rst_active_high = 1'b0;
      s_valid = 0; s_data = '0; s_last = 0; swap_req = 0; clear_err = 0;
      model_reset();
      #1;
      async_reset("reset");

      // Reset then idle: s_ready rises one edge after release.
      idle(2, "idle");

      // Ascending load, swap.
      for (int i = 0; i < TC; i++) ld_data[i] = TW'(i + 1);
      send_load(TC, TC, "load1");
      chk("load1.full_after_last", BW'(shadow_full), BW'(1));
      swap_now("swap1");
      chk("swap1.tap0",  BW'(coeff_out[0 +: TW]),        BW'(16'h0001));
      chk("swap1.tap39", BW'(coeff_out[39*TW +: TW]),    BW'(16'h0028));

      // Most negative tap everywhere.
      for (int i = 0; i < TC; i++) ld_data[i] = 16'h8000;
      send_load(TC, TC, "load2");
      swap_now("swap2");
      chk("swap2.tap17", BW'(coeff_out[17*TW +: TW]), BW'(16'h8000));

      // Load without swap leaves the active bank alone; held words are refused while full.
      for (int i = 0; i < TC; i++) ld_data[i] = 16'h7FFF;
      send_load(TC, TC, "load3");
      for (int i = 0; i < 3; i++) drive(1, 16'h1234, 0, 0, 0, "hold_full");
      chk("load3.tap5_unchanged", BW'(coeff_out[5*TW +: TW]), BW'(16'h8000));
      swap_now("swap3");

      // Early s_last on word 10.
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      send_load(10, 10, "early_last");
      chk("early_last.err", BW'(load_error), BW'(1));
      drive(0, '0, 0, 1, 0, "early_last.swap_ignored");
      drive(0, '0, 0, 0, 0, "early_last.after_swap");
      drive(0, '0, 0, 0, 1, "early_last.clear");
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      send_load(TC, TC, "clean_load");
      swap_now("swap4");

      // Word 40 without s_last.
      clear_err = 0;
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      send_load(TC, 0, "no_last");
      chk("no_last.err", BW'(load_error), BW'(1));
      drive(0, '0, 0, 0, 1, "no_last.clear");

      // swap_req alongside the final word is too early; the next one counts.
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      send_load(TC - 1, 0, "same_edge");
      drive(1, ld_data[TC-1], 1, 1, 0, "same_edge.last_with_swap");
      drive(0, '0, 0, 0, 0, "same_edge.no_swap");
      chk("same_edge.still_full", BW'(shadow_full), BW'(1));
      swap_now("swap5");

      // Asynchronous reset in the middle of a load.
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      send_load(20, 0, "midload");
      async_reset("midload");
      for (int i = 0; i < TC; i++) ld_data[i] = TW'($urandom);
      idle(1, "post_reset");
      send_load(TC, TC, "post_reset_load");
      swap_now("swap6");

      // Random traffic; s_last mostly lands on the final word.
      for (int c = 0; c < 3000; c++) begin
         bit v, l, sw, clr;
         v   = ($urandom_range(0, 3) != 0);
         l   = (m_cnt == TC - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 80) == 0);
         sw  = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 3) == 0);
         drive(v, TW'($urandom), l, sw, clr, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
